// File: rtl/i_cache_axi_rd.sv
// rtl/i_cache_axi_rd.sv - I-cache refill to single-beat AXI4 read bridge
//
// Purpose: each refill request from the instruction cache becomes one
// single-beat AXI4 read burst. The 32-bit word chosen by address bit 2 is
// returned on cache_or_data, together with a one-cycle cache_in_ok pulse.
// The bridge has no write channels.
//
// Ports:
//   clk, rst                 clock and synchronous active-high reset
//   cache_read_ena           refill request (level, held until served)
//   cache_addr               refill byte address
//   cache_or_data            fetched instruction word (registered)
//   cache_in_ok              one-cycle completion pulse
//   rd_err                   one-cycle error flag, coincident with cache_in_ok
//   ar_*                     AXI4 read address channel (master side)
//   r_*                      AXI4 read data channel (master side)

module i_cache_axi_rd #(
    parameter logic [3:0] AXI_ID     = 4'd0,
    parameter int         AXI_DATA_W = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cache_read_ena,
    input  logic [63:0]           cache_addr,
    output logic [31:0]           cache_or_data,
    output logic                  cache_in_ok,
    output logic                  rd_err,
    output logic                  ar_valid,
    input  logic                  ar_ready,
    output logic [63:0]           ar_addr,
    output logic [3:0]            ar_id,
    output logic [7:0]            ar_len,
    output logic [2:0]            ar_size,
    output logic [1:0]            ar_burst,
    input  logic                  r_valid,
    output logic                  r_ready,
    input  logic [AXI_DATA_W-1:0] r_data,
    input  logic [1:0]            r_resp,
    input  logic                  r_last,
    input  logic [3:0]            r_id
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        ADDR     = 3'd1,
        DATA     = 3'd2,
        DONE     = 3'd3,
        WAIT_LOW = 3'd4
    } state_t;

    state_t      state_q;
    logic        ar_valid_q;
    logic [63:0] ar_addr_q;
    logic        r_ready_q;
    logic        ok_q;
    logic        err_q;
    logic [31:0] data_q;
    // Only address bit 2 matters after the request is latched: it picks the lane.
    logic        lane_q;

    // Fixed burst shape: one 4-byte beat, INCR.
    assign ar_id    = AXI_ID;
    assign ar_len   = 8'd0;
    assign ar_size  = 3'b010;
    assign ar_burst = 2'b01;

    assign ar_valid      = ar_valid_q;
    assign ar_addr       = ar_addr_q;
    assign r_ready       = r_ready_q;
    assign cache_in_ok   = ok_q;
    assign rd_err        = err_q;
    assign cache_or_data = data_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            ar_valid_q <= 1'b0;
            ar_addr_q  <= '0;
            r_ready_q  <= 1'b0;
            ok_q       <= 1'b0;
            err_q      <= 1'b0;
            data_q     <= '0;
            lane_q     <= 1'b0;
        end else begin
            // Completion flags are single-cycle pulses; only DATA->DONE raises them.
            ok_q  <= 1'b0;
            err_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (cache_read_ena) begin
                        lane_q     <= cache_addr[2];
                        ar_addr_q  <= cache_addr & ~64'h3;
                        ar_valid_q <= 1'b1;
                        state_q    <= ADDR;
                    end
                end
                ADDR: begin
                    // ar_valid_q is always 1 here, so ar_ready alone completes the handshake.
                    if (ar_ready) begin
                        ar_valid_q <= 1'b0;
                        r_ready_q  <= 1'b1;
                        state_q    <= DATA;
                    end
                end
                DATA: begin
                    if (r_valid) begin
                        data_q    <= lane_q ? r_data[AXI_DATA_W-1 -: 32] : r_data[31:0];
                        err_q     <= (r_resp != 2'b00) || !r_last || (r_id != AXI_ID);
                        ok_q      <= 1'b1;
                        r_ready_q <= 1'b0;
                        state_q   <= DONE;
                    end
                end
                DONE: begin
                    state_q <= WAIT_LOW;
                end
                WAIT_LOW: begin
                    // The cache keeps its enable high briefly after ok; wait for it
                    // to drop so the same request is not issued twice.
                    if (!cache_read_ena) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q    <= IDLE;
                    ar_valid_q <= 1'b0;
                    r_ready_q  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_i_cache_axi_rd.sv
// tb/tb_i_cache_axi_rd.sv - directed self-checking bench for i_cache_axi_rd

module tb_i_cache_axi_rd;

    logic        clk;
    logic        rst;
    logic        ena;
    logic [63:0] addr;
    logic [31:0] or_data;
    logic        ok;
    logic        err;
    logic        arv;
    logic        arr;
    logic [63:0] araddr;
    logic [3:0]  arid;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        rv;
    logic        rr;
    logic [63:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic [3:0]  rid;

    int n_checks = 0;
    int n_fail   = 0;

    i_cache_axi_rd #(
        .AXI_ID     (4'd0),
        .AXI_DATA_W (64)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .cache_read_ena (ena),
        .cache_addr     (addr),
        .cache_or_data  (or_data),
        .cache_in_ok    (ok),
        .rd_err         (err),
        .ar_valid       (arv),
        .ar_ready       (arr),
        .ar_addr        (araddr),
        .ar_id          (arid),
        .ar_len         (arlen),
        .ar_size        (arsize),
        .ar_burst       (arburst),
        .r_valid        (rv),
        .r_ready        (rr),
        .r_data         (rdata),
        .r_resp         (rresp),
        .r_last         (rlast),
        .r_id           (rid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [63:0] a_tab [3];
        logic [31:0] d_tab [3];
        logic        e_tab [3];

        rst = 1'b1; ena = 1'b0; addr = '0; arr = 1'b0;
        rv = 1'b0; rdata = '0; rresp = 2'b00; rlast = 1'b1; rid = 4'd0;
        tick(); tick();

        // Reset state and constant AR fields
        chk("rst_ar_valid", arv, 0);
        chk("rst_r_ready", rr, 0);
        chk("rst_ok", ok, 0);
        chk("rst_err", err, 0);
        chk("rst_data", or_data, 0);
        chk("rst_ar_addr", araddr, 0);
        chk("ar_id", arid, 0);
        chk("ar_len", arlen, 0);
        chk("ar_size", arsize, 3'b010);
        chk("ar_burst", arburst, 2'b01);
        rst = 1'b0;
        tick();

        // Minimum latency, upper lane
        addr = 64'h8000_0004; ena = 1'b1; arr = 1'b1;
        chk("t1_idle_arv", arv, 0);
        tick();
        chk("t1_arv", arv, 1);
        chk("t1_araddr", araddr, 64'h8000_0004);
        chk("t1_rr_early", rr, 0);
        tick();
        chk("t1_arv_drop", arv, 0);
        chk("t1_rr", rr, 1);
        chk("t1_ok_early", ok, 0);
        rv = 1'b1; rdata = 64'h11223344_55667788; rresp = 2'b00; rlast = 1'b1;
        tick();
        chk("t1_ok", ok, 1);
        chk("t1_data", or_data, 32'h11223344);
        chk("t1_err", err, 0);
        chk("t1_rr_drop", rr, 0);
        rv = 1'b0;
        tick();
        chk("t1_ok_pulse", ok, 0);
        chk("t1_no_reissue", arv, 0);
        ena = 1'b0;
        tick();

        // AR stall of 5 cycles, ena dropped and r_valid asserted while in ADDR
        addr = 64'h8000_0008; ena = 1'b1; arr = 1'b0;
        tick();
        for (int i = 0; i < 5; i++) begin
            chk("t2_arv_hold", arv, 1);
            chk("t2_araddr_hold", araddr, 64'h8000_0008);
            chk("t2_rr_low", rr, 0);
            chk("t2_no_ok", ok, 0);
            if (i == 0) begin
                ena = 1'b0; addr = 64'h8000_0FF4;
                rv = 1'b1; rdata = 64'hFFFF_FFFF_FFFF_FFFF;
            end
            tick();
        end
        rv = 1'b0; arr = 1'b1;
        chk("t2_arv_hs", arv, 1);
        tick();
        chk("t2_arv_drop", arv, 0);
        chk("t2_rr", rr, 1);
        arr = 1'b0; rv = 1'b1; rdata = 64'h11223344_55667788;
        tick();
        chk("t2_ok", ok, 1);
        chk("t2_data", or_data, 32'h55667788);
        chk("t2_err", err, 0);
        rv = 1'b0;
        tick();
        chk("t2_ok_pulse", ok, 0);
        tick();

        // SLVERR response still loads the lane
        addr = 64'h8000_0004; ena = 1'b1; arr = 1'b1;
        tick();
        chk("t3_arv", arv, 1);
        tick();
        chk("t3_rr", rr, 1);
        rv = 1'b1; rdata = 64'hDEADBEEF_CAFEF00D; rresp = 2'b10;
        tick();
        chk("t3_ok", ok, 1);
        chk("t3_err", err, 1);
        chk("t3_data", or_data, 32'hDEADBEEF);
        rv = 1'b0; rresp = 2'b00;

        // Enable held high after ok: no second AR
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("t4_no_ar", arv, 0);
            chk("t4_no_ok", ok, 0);
            chk("t4_no_err", err, 0);
        end
        ena = 1'b0;
        tick();
        addr = 64'h8000_0010; ena = 1'b1;
        tick();
        chk("t4_arv", arv, 1);
        chk("t4_araddr", araddr, 64'h8000_0010);
        tick();
        chk("t4_rr", rr, 1);

        // Reset while in DATA, then a late beat
        rst = 1'b1;
        tick();
        chk("t5_arv", arv, 0);
        chk("t5_rr", rr, 0);
        chk("t5_ok", ok, 0);
        rst = 1'b0; ena = 1'b0; arr = 1'b0;
        rv = 1'b1; rdata = 64'h12345678_9ABCDEF0;
        tick();
        chk("t5_late_rr", rr, 0);
        chk("t5_late_ok", ok, 0);
        tick();
        chk("t5_late_ok2", ok, 0);
        chk("t5_data", or_data, 0);
        rv = 1'b0;
        tick();

        // Back-to-back requests; second has wrong r_id, third lacks r_last
        a_tab[0] = 64'h0; a_tab[1] = 64'h4; a_tab[2] = 64'h8;
        d_tab[0] = 32'hB000_0000; d_tab[1] = 32'hA000_0001; d_tab[2] = 32'hB000_0002;
        e_tab[0] = 1'b0; e_tab[1] = 1'b1; e_tab[2] = 1'b1;
        for (int k = 0; k < 3; k++) begin
            addr = a_tab[k]; ena = 1'b1; arr = 1'b1;
            tick();
            chk("t6_arv", arv, 1);
            chk("t6_araddr", araddr, a_tab[k]);
            tick();
            chk("t6_rr", rr, 1);
            rv = 1'b1;
            rdata = {32'hA000_0000 + 32'(k), 32'hB000_0000 + 32'(k)};
            rid   = (k == 1) ? 4'd3 : 4'd0;
            rlast = (k == 2) ? 1'b0 : 1'b1;
            tick();
            chk("t6_ok", ok, 1);
            chk("t6_data", or_data, d_tab[k]);
            chk("t6_err", err, e_tab[k]);
            ena = 1'b0; rv = 1'b0; rid = 4'd0; rlast = 1'b1;
            tick();
            chk("t6_ok_not_consec", ok, 0);
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/i_cache_axi_rd.md
Name: i_cache_axi_rd

Overview:
- Read-only AXI4 master bridge. Sits directly downstream of the instruction cache refill port.
- Converts each cache refill request (cache_read_ena / cache_addr) into one single-beat AXI4 read burst.
- Returns the selected 32-bit instruction word on cache_or_data with a one-cycle cache_in_ok pulse.
- Feeds the system AXI interconnect; has no write channels.

Parameters:
- AXI_ID, 4'd0, constant value driven on ar_id; the r_id of every response must match it.
- AXI_DATA_W, 64, R-channel data width; only 64 is supported.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- cache_read_ena  in  1  refill request from the I-cache; level, held until served
- cache_addr  in  64  refill byte address
- cache_or_data  out  32  fetched instruction word
- cache_in_ok  out  1  one-cycle pulse; cache_or_data is valid in this cycle
- rd_err  out  1  one-cycle pulse coincident with cache_in_ok when the response was bad
- ar_valid  out  1  AXI read address valid
- ar_ready  in  1  AXI read address ready
- ar_addr  out  64  AXI read address
- ar_id  out  4  AXI read ID
- ar_len  out  8  AXI burst length
- ar_size  out  3  AXI burst size
- ar_burst  out  2  AXI burst type
- r_valid  in  1  AXI read data valid
- r_ready  out  1  AXI read data ready
- r_data  in  64  AXI read data
- r_resp  in  2  AXI read response
- r_last  in  1  AXI last beat
- r_id  in  4  AXI read ID

Behaviour:
- Clock and reset: single clock clk; reset rst is synchronous, active-high.
- Reset values: state=IDLE, ar_valid=0, r_ready=0, cache_in_ok=0, rd_err=0, cache_or_data=0, ar_addr=0, latched addr=0.
- Constant outputs: ar_id=AXI_ID, ar_len=8'd0, ar_size=3'b010 (4 B), ar_burst=2'b01 (INCR).
- IDLE: on cache_read_ena=1, latch cache_addr; set ar_addr={cache_addr[63:2],2'b00}; set ar_valid=1 from the next cycle; go to ADDR.
- ADDR:
  - Hold ar_valid and ar_addr stable until ar_valid&&ar_ready.
  - In the handshake cycle, go to DATA with ar_valid=0 and r_ready=1 from the next cycle.
  - ar_valid never drops before the handshake (AXI rule).
- DATA:
  - r_ready=1. On r_valid (r_id must equal AXI_ID; r_last is expected to be 1):
    - cache_or_data <= latched addr[2] ? r_data[63:32] : r_data[31:0].
    - err <= (r_resp!=2'b00) || !r_last || (r_id!=AXI_ID).
    - Go to DONE with r_ready=0 from the next cycle.
  - Beats arriving after r_last is accepted are not consumed; r_ready is already 0.
- DONE:
  - cache_in_ok=1 and rd_err=err for exactly this cycle.
  - cache_or_data stays registered and unchanged until the next DONE.
  - Next state is WAIT_LOW.
- WAIT_LOW:
  - Stay here while cache_read_ena=1, so a held request is not re-issued; the cache keeps its enable high for a few cycles after ok.
  - On cache_read_ena=0, go to IDLE.
- Latency:
  - Request sampled in cycle N gives ar_valid in cycle N+1.
  - With ar_ready=1 and r_valid in the first possible cycle, r_ready is high in N+2, cache_in_ok in N+3 at minimum.
  - Any AR or R stall adds cycles one for one.
- Address change mid-transaction: ignored; the latched address governs the lane select.
- cache_read_ena dropping in ADDR or DATA: the transaction still completes and cache_in_ok still pulses.
- Reset mid-operation: returns to IDLE at the next edge and drops all handshake outputs. Any later R beat from the aborted transaction is not accepted.
- Simultaneous events: ar_ready and r_valid are never acted on in the same state. An r_valid seen while in ADDR is not accepted.
- cache_in_ok is never high on two consecutive cycles.

Test Plan:
- cache_addr=0x8000_0004, ar_ready=1, r_valid one cycle after r_ready, r_data=0x11223344_55667788, r_resp=0, r_last=1 -> ar_addr=0x8000_0004, cache_or_data=0x11223344, single cache_in_ok pulse at N+3, rd_err=0.
- cache_addr=0x8000_0008 with ar_ready held low 5 cycles -> ar_valid and ar_addr stable for all 5 cycles; r_data low word 0x55667788 returned; cache_in_ok delayed by exactly 5 cycles.
- r_resp=2'b10 (SLVERR) -> cache_in_ok=1 with rd_err=1 in the same cycle; cache_or_data still loaded from the lane.
- cache_read_ena held high 4 cycles after cache_in_ok -> no second AR issued; drop to 0, then raise with addr 0x8000_0010 -> new AR with ar_addr=0x8000_0010.
- rst asserted in DATA while r_ready=1 -> next cycle ar_valid=0, r_ready=0, cache_in_ok=0; a late r_valid is not accepted.
- Back-to-back requests at 0x0, 0x4, 0x8, each separated by one low cycle of ena -> three ok pulses, correct lanes, never two consecutive ok cycles.
